axis_gbox_arb: RTL
==================

# axis_gbox_arb

Round-robin, packet-locked arbiter that shares one AXIS gear box between `NB_PORTS` upstream requesters. It sits directly in front of the gear box's `up_*` port and multiplexes one requester's stream through at a time. The grant is held from the first beat to the beat carrying `last`, so packets are never interleaved. It tags the forwarded stream with the granted port index so downstream logic can route or count per source.

## Interface
Parameters:
- `NB_PORTS`, 4: number of requester streams; legal range ≥2.
- `DATA_WIDTH`, 8: width of each requester word; equals the gear box `DATA_UP_WIDTH`.
- `ID_WIDTH`, 2: width of `dn_id`; must satisfy 2**`ID_WIDTH` ≥ `NB_PORTS`.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `up_data`  in  `NB_PORTS*DATA_WIDTH`  packed requester data; port p occupies `[p*DATA_WIDTH +: DATA_WIDTH]`.
- `up_last`  in  `NB_PORTS`  per-port end-of-packet flag.
- `up_val`  in  `NB_PORTS`  per-port valid.
- `up_rdy`  out  `NB_PORTS`  per-port ready; at most one bit high.
- `dn_data`  out  `DATA_WIDTH`  forwarded data, to gear box `up_data`.
- `dn_last`  out  1  forwarded last.
- `dn_val`  out  1  forwarded valid.
- `dn_rdy`  in  1  ready from gear box `up_rdy`.
- `dn_id`  out  `ID_WIDTH`  index of the granted port; 0 when idle.

## Operation
- A beat transfers on port p when `up_val[p] & up_rdy[p]`. Downstream, a beat transfers when `dn_val & dn_rdy`.
- State `IDLE`:
  - All `up_rdy` and `dn_val` outputs are 0. `dn_data` and `dn_last` are 0.
  - If any `up_val` bit is set, the block selects the first port with `up_val` set, searching upward from `ptr` with wrap-around.
  - It registers that port as `grant` and moves to `BUSY`.
- State `BUSY`, with granted port g:
  - `dn_data`, `dn_last` and `dn_val` equal port g's `up_data`, `up_last` and `up_val`, combinationally.
  - `up_rdy[g]` = `dn_rdy`; all other `up_rdy` bits are 0.
  - `dn_id` = g.
  - When `up_val[g] & dn_rdy & up_last[g]`, the block moves to `IDLE` and sets `ptr` to (g+1) mod `NB_PORTS`.
- `ptr` changes only on packet completion. The last-served port therefore has the lowest priority at the next arbitration.
- A requester that deasserts `up_val` mid-packet keeps the grant. The arbiter waits indefinitely for `last`; there is no timeout.
- `up_val` bits that go high and then low while the block is `IDLE` are not latched. Only the value sampled on the arbitration edge counts.
- Requesters must hold `up_val`/`up_data` until accepted (AXIS rule). The arbiter does not check this.

## Timing
- Reset state: `IDLE`, `grant`=0, `ptr`=0. All outputs are 0: `up_rdy`, `dn_val`, `dn_last`, `dn_data`, `dn_id`.
- Arbitration latency:
  - If `up_val[p]` is high in `IDLE` at edge N, `BUSY` starts at edge N.
  - The first beat can transfer in cycle N+1, which is the first `BUSY` cycle.
- Pass-through in `BUSY` is zero-latency combinational, with no register stage. `dn_rdy` → `up_rdy[g]` is a combinational path.
- Packet boundary:
  - The cycle after a `last` transfer is always one `IDLE` arbitration cycle.
  - Back-to-back packets therefore have a minimum gap of one cycle. Peak throughput for a stream of single-beat packets is 1/2.
- Simultaneous events:
  - Several `up_val` bits high in `IDLE`: the round-robin winner from `ptr` is selected. Losers see `up_rdy`=0 and hold.
  - `last` transfer while other ports are requesting: they are arbitrated in the following `IDLE` cycle.
- `dn_rdy` low in `BUSY`: `up_rdy[g]`=0 and no beat moves. `dn_val` still mirrors `up_val[g]`, per the AXIS valid-before-ready rule.
- Reset mid-packet: on the reset edge the block goes to `IDLE` with `ptr`=0. Outputs are 0 from the next cycle. Downstream sees a truncated packet with no `last`; system-level reset of the gear box is required alongside.

## Test plan
- Single requester: after reset, port 2 presents a 3-beat packet (0x11, 0x22, 0x33 with last), `dn_rdy`=1.
  - Required: `IDLE` for one cycle, then `dn_id`=2 and three consecutive `dn_val` beats with matching data. `dn_last` is set on 0x33 only. Then `IDLE` and `ptr`=3.
- Round-robin fairness: all 4 ports continuously offer 2-beat packets, starting from `ptr`=0.
  - Required: grant order 0,1,2,3,0,… with one idle cycle between packets. No beats from a non-granted port appear on `dn_*`.
- Backpressure: port 1 sends 4 beats while `dn_rdy` toggles 1,0,0,1,1,0,1,1.
  - Required: `up_rdy[1]` exactly equals `dn_rdy`. All 4 words arrive in order with no duplication or loss, and the grant is held throughout.
- Valid gap: port 3 drops `up_val` for 5 cycles between beats 1 and 2 while port 0 requests.
  - Required: the grant stays on 3 and `up_rdy[0]`=0 throughout. Port 0 is served only after port 3's `last`.
- Single-beat packets: ports 0 and 1 each send a stream of one-beat `last` packets.
  - Required: the `dn_id` sequence is 0,1,0,1,… and each `dn_val` pulse is separated by one idle cycle.
- Reset mid-packet: `rst` is asserted during beat 2 of a 4-beat packet from port 2.
  - Required: the next cycle has all outputs 0 and the state `IDLE`. With ports 1 and 2 both requesting afterwards, port 1 is granted first because `ptr`=0.

Source files
------------

// File: rtl/axis_gbox_arb_if.sv
// Handshake bundle between requesters, arbiter and gear box.
// Requester side is packed per port; downstream side is one stream.
interface axis_gbox_arb_if #(
  parameter int NB_PORTS   = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = 2
);
  logic [NB_PORTS*DATA_WIDTH-1:0] up_data;
  logic [NB_PORTS-1:0]            up_last;
  logic [NB_PORTS-1:0]            up_val;
  logic [NB_PORTS-1:0]            up_rdy;
  logic [DATA_WIDTH-1:0]          dn_data;
  logic                           dn_last;
  logic                           dn_val;
  logic                           dn_rdy;
  logic [ID_WIDTH-1:0]            dn_id;

  modport slave (
    input  up_data, up_last, up_val, dn_rdy,
    output up_rdy, dn_data, dn_last, dn_val, dn_id
  );

  modport master (
    output up_data, up_last, up_val, dn_rdy,
    input  up_rdy, dn_data, dn_last, dn_val, dn_id
  );
endinterface

// File: rtl/axis_gbox_arb.sv
// Round-robin, packet-locked arbiter in front of the gear box.
// Grant is held from first beat to last; dn_id tags the source.
module axis_gbox_arb #(
  parameter int NB_PORTS   = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = 2
) (
  input  logic             clk,
  input  logic             rst,
  axis_gbox_arb_if.slave   bus
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                state, state_nxt;
  logic [ID_WIDTH-1:0]   grant, grant_nxt;
  logic [ID_WIDTH-1:0]   ptr, ptr_nxt;
  logic [ID_WIDTH-1:0]   sel;
  logic                  found;
  logic                  g_val;
  logic                  g_last;
  logic [DATA_WIDTH-1:0] g_data;

  // First requesting port at or above ptr, else wrap to lowest
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int p = 0; p < NB_PORTS; p++) begin
      if (!found && bus.up_val[p] && ID_WIDTH'(p) >= ptr) begin
        found = 1'b1;
        sel   = ID_WIDTH'(p);
      end
    end
    for (int p = 0; p < NB_PORTS; p++) begin
      if (!found && bus.up_val[p]) begin
        found = 1'b1;
        sel   = ID_WIDTH'(p);
      end
    end
  end

  // Select the granted port's stream
  always_comb begin
    g_val  = 1'b0;
    g_last = 1'b0;
    g_data = '0;
    for (int p = 0; p < NB_PORTS; p++) begin
      if (grant == ID_WIDTH'(p)) begin
        g_val  = bus.up_val[p];
        g_last = bus.up_last[p];
        g_data = bus.up_data[p*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Next state and combinational pass-through
  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    ptr_nxt     = ptr;
    bus.up_rdy  = '0;
    bus.dn_data = '0;
    bus.dn_last = 1'b0;
    bus.dn_val  = 1'b0;
    bus.dn_id   = '0;
    unique case (state)
      IDLE: begin
        if (found) begin
          grant_nxt = sel;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        bus.dn_data = g_data;
        bus.dn_last = g_last;
        bus.dn_val  = g_val;
        bus.dn_id   = grant;
        for (int p = 0; p < NB_PORTS; p++) begin
          bus.up_rdy[p] = (grant == ID_WIDTH'(p)) & bus.dn_rdy;
        end
        if (g_val && bus.dn_rdy && g_last) begin
          state_nxt = IDLE;
          if (grant == ID_WIDTH'(NB_PORTS - 1)) begin
            ptr_nxt = '0;
          end else begin
            ptr_nxt = grant + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, grant and round-robin pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      ptr   <= ptr_nxt;
    end
  end

endmodule
